// File: rtl/assoc_cache_counter.sv
// N-way set-associative tag store with LRU replacement, modelled miss-fill latency,
// single-outstanding request/response handshake, sequential flush and saturating statistics.
module assoc_cache_counter #(
  parameter int ADDR_W       = 32,
  parameter int OFFSET_W     = 2,
  parameter int INDEX_W      = 8,
  parameter int WAYS         = 2,
  parameter int CNT_W        = 32,
  parameter int MISS_PENALTY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_hit,
  input  logic              flush,
  input  logic              clr_stats,
  output logic              busy,
  output logic [CNT_W-1:0]  Hitcount,
  output logic [CNT_W-1:0]  Misscount,
  output logic [CNT_W-1:0]  Accesscount
);

  // state  | meaning
  // IDLE   | waiting for a request or flush
  // LOOKUP | tag compare against the registered set
  // FILL   | miss penalty countdown, installs tag on the last cycle
  // FLUSH  | invalidating one set per cycle
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PEN_W = $clog2(MISS_PENALTY + 1);
  localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(WAYS - 1);

  logic [1:0]         state, state_nxt;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [PEN_W-1:0]   pen_cnt;
  logic [INDEX_W-1:0] flush_idx;
  logic               flush_pend, pend_nxt;

  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]  valid_mem [SETS];
  logic [AGE_W-1:0] age_mem   [SETS][WAYS];

  logic             accept, hit_any, lookup_hit, lookup_miss, fill_done, flush_done, touch;
  logic [AGE_W-1:0] hit_way, victim_way, touch_way, touch_age;
  logic [AGE_W-1:0] age_upd [WAYS];
  logic             unused_offset;

  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  assign accept      = (state == S_IDLE) && req_valid && req_ready && !flush && !flush_pend;
  assign lookup_hit  = (state == S_LOOKUP) && hit_any;
  assign lookup_miss = (state == S_LOOKUP) && !hit_any;
  assign fill_done   = (state == S_FILL) && (pen_cnt == PEN_W'(1));
  assign flush_done  = (state == S_FLUSH) && (&flush_idx);
  assign touch       = lookup_hit || fill_done;
  assign touch_way   = lookup_hit ? hit_way : victim_way;

  always_comb begin
    hit_any    = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[idx_q][w] && tag_mem[idx_q][w] == tag_q) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_mem[idx_q][w] == MAX_AGE) victim_way = AGE_W'(w);
    end
    // invalid ways take precedence; descending scan leaves the lowest one selected
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[idx_q][w]) victim_way = AGE_W'(w);
    end
  end

  always_comb begin
    touch_age = age_mem[idx_q][touch_way];
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touch_way)              age_upd[w] = '0;
      else if (age_mem[idx_q][w] < touch_age) age_upd[w] = age_mem[idx_q][w] + 1'b1;
      else                                    age_upd[w] = age_mem[idx_q][w];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (flush || flush_pend) state_nxt = S_FLUSH;
                else if (accept)         state_nxt = S_LOOKUP;
      S_LOOKUP: if (!hit_any)            state_nxt = S_FILL;
                else                     state_nxt = (flush || flush_pend) ? S_FLUSH : S_IDLE;
      S_FILL:   if (fill_done)           state_nxt = (flush || flush_pend) ? S_FLUSH : S_IDLE;
      S_FLUSH:  if (flush_done)          state_nxt = (flush || flush_pend) ? S_FLUSH : S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
    pend_nxt = flush_pend | (flush & (state != S_IDLE));
    // a pending flush is consumed when a fresh flush sweep starts
    if (state_nxt == S_FLUSH && (state != S_FLUSH || flush_done)) pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      flush_pend <= 1'b0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      tag_q      <= '0;
      idx_q      <= '0;
      pen_cnt    <= '0;
      flush_idx  <= '0;
    end else begin
      state      <= state_nxt;
      flush_pend <= pend_nxt;
      req_ready  <= (state_nxt == S_IDLE) && !pend_nxt;
      busy       <= (state_nxt != S_IDLE);
      resp_valid <= touch;
      resp_hit   <= lookup_hit;
      if (accept) begin
        tag_q <= req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
        idx_q <= req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
      end
      if (lookup_miss)          pen_cnt <= PEN_W'(MISS_PENALTY);
      else if (state == S_FILL) pen_cnt <= pen_cnt - 1'b1;
      if (state == S_FLUSH)     flush_idx <= flush_idx + 1'b1;
      else                      flush_idx <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_mem[s][w] <= AGE_W'(w);
      end
    end else if (state == S_FLUSH) begin
      valid_mem[flush_idx] <= '0;
      for (int w = 0; w < WAYS; w++) age_mem[flush_idx][w] <= AGE_W'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) age_mem[idx_q][w] <= age_upd[w];
      if (fill_done) valid_mem[idx_q][victim_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) tag_mem[idx_q][victim_way] <= tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hitcount    <= '0;
      Misscount   <= '0;
      Accesscount <= '0;
    end else if (clr_stats) begin
      Hitcount    <= '0;
      Misscount   <= '0;
      Accesscount <= '0;
    end else if (touch) begin
      if (lookup_hit && Hitcount != '1) Hitcount  <= Hitcount + 1'b1;
      if (fill_done && Misscount != '1) Misscount <= Misscount + 1'b1;
      if (Accesscount != '1)            Accesscount <= Accesscount + 1'b1;
    end
  end

endmodule

// File: tb/tb_assoc_cache_counter.sv
// Directed bench for assoc_cache_counter: a 2-way, a direct-mapped and a 4-bit-counter
// instance share one request bus, steered by sel.
module tb_assoc_cache_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        clr_stats = 1'b0;
  int          sel = 0;
  int          total = 0;
  int          bad = 0;

  logic        rdy_a, rv_a, hit_a, busy_a;
  logic        rdy_b, rv_b, hit_b, busy_b;
  logic        rdy_c, rv_c, hit_c, busy_c;
  logic [31:0] hc_a, mc_a, ac_a, hc_b, mc_b, ac_b;
  logic [3:0]  hc_c, mc_c, ac_c;

  logic        m_rdy, m_rv, m_hit, m_busy;
  logic [31:0] m_hc, m_mc, m_ac;

  always #5 clk = ~clk;

  assoc_cache_counter #(.ADDR_W(32), .OFFSET_W(2), .INDEX_W(2), .WAYS(2), .CNT_W(32), .MISS_PENALTY(3)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_addr(req_addr),
    .req_ready(rdy_a), .resp_valid(rv_a), .resp_hit(hit_a),
    .flush(flush && sel == 0), .clr_stats(clr_stats && sel == 0), .busy(busy_a),
    .Hitcount(hc_a), .Misscount(mc_a), .Accesscount(ac_a));

  assoc_cache_counter #(.ADDR_W(32), .OFFSET_W(2), .INDEX_W(2), .WAYS(1), .CNT_W(32), .MISS_PENALTY(3)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_addr(req_addr),
    .req_ready(rdy_b), .resp_valid(rv_b), .resp_hit(hit_b),
    .flush(flush && sel == 1), .clr_stats(clr_stats && sel == 1), .busy(busy_b),
    .Hitcount(hc_b), .Misscount(mc_b), .Accesscount(ac_b));

  assoc_cache_counter #(.ADDR_W(32), .OFFSET_W(2), .INDEX_W(2), .WAYS(2), .CNT_W(4), .MISS_PENALTY(3)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2), .req_addr(req_addr),
    .req_ready(rdy_c), .resp_valid(rv_c), .resp_hit(hit_c),
    .flush(flush && sel == 2), .clr_stats(clr_stats && sel == 2), .busy(busy_c),
    .Hitcount(hc_c), .Misscount(mc_c), .Accesscount(ac_c));

  always_comb begin
    m_rdy = rdy_a; m_rv = rv_a; m_hit = hit_a; m_busy = busy_a;
    m_hc = hc_a; m_mc = mc_a; m_ac = ac_a;
    if (sel == 1) begin
      m_rdy = rdy_b; m_rv = rv_b; m_hit = hit_b; m_busy = busy_b;
      m_hc = hc_b; m_mc = mc_b; m_ac = ac_b;
    end else if (sel == 2) begin
      m_rdy = rdy_c; m_rv = rv_c; m_hit = hit_c; m_busy = busy_c;
      m_hc = 32'(hc_c); m_mc = 32'(mc_c); m_ac = 32'(ac_c);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int h, input int m, input int a);
    check_val({tag, "_hit"}, m_hc, h);
    check_val({tag, "_miss"}, m_mc, m);
    check_val({tag, "_acc"}, m_ac, a);
  endtask

  // leaves the caller #1 after the accept edge
  task automatic issue(input logic [31:0] addr, input string tag);
    int n = 0;
    while (!m_rdy && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_rdy"}, 32'(m_rdy), 1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val({tag, "_rdy_low"}, 32'(m_rdy), 0);
  endtask

  task automatic do_access(input logic [31:0] addr, input logic exp_hit, input string tag);
    int n = 0;
    issue(addr, tag);
    do begin
      @(posedge clk); #1; n++;
    end while (!m_rv && n < 20);
    check_val({tag, "_lat"}, n, exp_hit ? 1 : 4);
    check_val({tag, "_kind"}, 32'(m_hit), 32'(exp_hit));
  endtask

  initial begin
    #1;
    check_val("rst_rdy", 32'(rdy_a), 0);
    check_val("rst_busy", 32'(busy_a), 0);
    check_val("rst_rv", 32'(rv_a), 0);
    check_counts("rst", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_rdy", 32'(rdy_a), 1);

    sel = 0;
    do_access(32'h00, 1'b0, "basic_m");
    check_counts("basic1", 0, 1, 1);
    do_access(32'h00, 1'b1, "basic_h");
    check_counts("basic2", 1, 1, 2);

    // LRU conflict in set 1: M M H M M M
    do_access(32'h04, 1'b0, "lru0");
    do_access(32'h14, 1'b0, "lru1");
    do_access(32'h04, 1'b1, "lru2");
    do_access(32'h24, 1'b0, "lru3");
    do_access(32'h14, 1'b0, "lru4");
    do_access(32'h04, 1'b0, "lru5");
    check_counts("lru", 2, 6, 8);
    do_access(32'h04, 1'b1, "b2b0");
    do_access(32'h14, 1'b1, "b2b1");
    check_counts("b2b", 4, 6, 10);

    // flush and request together: flush wins
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h00;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("fp_busy", 32'(m_busy), 1);
      check_val("fp_rdy", 32'(m_rdy), 0);
      check_val("fp_rv", 32'(m_rv), 0);
      @(posedge clk); #1;
    end
    check_val("fp_done", 32'(m_busy), 0);
    do_access(32'h00, 1'b0, "fp_after");
    check_counts("fp", 4, 7, 11);

    // flush during FILL waits for the miss response
    issue(32'h10, "pend");
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    check_val("pend_rv_early", 32'(m_rv), 0);
    @(posedge clk); #1;
    check_val("pend_rv", 32'(m_rv), 1);
    check_val("pend_kind", 32'(m_hit), 0);
    for (int i = 0; i < 4; i++) begin
      check_val("pend_busy", 32'(m_busy), 1);
      check_val("pend_rdy", 32'(m_rdy), 0);
      @(posedge clk); #1;
    end
    check_val("pend_done", 32'(m_busy), 0);
    do_access(32'h10, 1'b0, "pend_after");
    check_counts("pend", 4, 9, 13);

    sel = 1;
    do_access(32'h00, 1'b0, "dm0");
    do_access(32'h10, 1'b0, "dm1");
    do_access(32'h00, 1'b0, "dm2");
    do_access(32'h04, 1'b0, "dm3");
    do_access(32'h04, 1'b1, "dm4");
    check_counts("dm", 1, 4, 5);

    sel = 2;
    for (int i = 0; i < 16; i++) begin
      do_access(32'(i) << 4, 1'b0, "sat");
      check_val("sat_miss", m_mc, (i + 1 > 15) ? 15 : i + 1);
    end
    check_counts("sat", 0, 15, 15);
    issue(32'hF0, "clr");
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    check_val("clr_rv", 32'(m_rv), 1);
    check_val("clr_kind", 32'(m_hit), 1);
    check_counts("clr", 0, 0, 0);
    do_access(32'hF0, 1'b1, "clr_after");
    check_counts("clr2", 1, 0, 1);

    // async reset in the middle of a fill
    sel = 0;
    issue(32'h20, "arst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("arst_rv", 32'(m_rv), 0);
    check_val("arst_rdy", 32'(m_rdy), 0);
    check_val("arst_busy", 32'(m_busy), 0);
    check_counts("arst", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (m_rv) seen++;
      end
      check_val("arst_no_resp", seen, 0);
    end
    do_access(32'h00, 1'b0, "arst_after");
    check_counts("arst2", 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
